// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : EX-stage ALU with a built-in funct/ALUOp decoder. Single-cycle
//             ADD/SUB/SLL/XOR/AND/SRA, plus multi-cycle unsigned MUL
//             (shift-add, MUL_STEP bits per cycle) and DIVU/REMU (restoring
//             division, one bit per cycle) behind a valid/ready handshake.
//  Ports    : clk_i, rst_i      - clock, synchronous active-high reset
//             valid_i/ready_o   - request handshake (accept on both high)
//             funct_i, ALUOp_i  - {funct7, funct3} and main-decoder ALUOp
//             rs1/rs2_data_i    - operands (immediate already muxed in)
//             valid_o           - one-cycle result strobe
//             result_o, zero_o  - result and result==0, held between strobes
//             illegal_o         - strobes with valid_o on undecodable ops
//             stall_o           - high while a multi-cycle op is iterating
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [9:0]      funct_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o,
    output logic            stall_o
);

    localparam int c_SHAMT_W = $clog2(XLEN);
    localparam int c_CNT_W   = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_XOR  = 4'd3,
        OP_AND  = 4'd4,
        OP_SRA  = 4'd5,
        OP_MUL  = 4'd6,
        OP_DIVU = 4'd7,
        OP_REMU = 4'd8,
        OP_ILL  = 4'd9
    } op_t;

    // Multi-cycle op kind remembered across BUSY
    typedef enum logic [1:0] {
        M_MUL  = 2'd0,
        M_DIVU = 2'd1,
        M_REMU = 2'd2
    } mop_t;

    state_t           state_q, state_d;
    mop_t             mop_q, mop_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic             zero_q, zero_d;
    logic [XLEN-1:0]  result_q, result_d;
    // a: multiplicand (MUL) or dividend/quotient shift register (DIV)
    // b: multiplier (MUL) or divisor (DIV)
    // acc: partial product (MUL) or partial remainder (DIV)
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]       w_f7;
    logic [2:0]       w_f3;
    op_t              w_op;
    logic [XLEN-1:0]  w_alu_res;
    logic [c_SHAMT_W-1:0] w_shamt;

    logic [XLEN-1:0]  w_mul_sum;
    logic [XLEN-1:0]  w_mul_acc_next;
    logic [XLEN:0]    w_rem_shift;
    logic             w_div_ge;
    logic [XLEN-1:0]  w_div_diff;
    logic [XLEN-1:0]  w_div_rem_next;
    logic [XLEN-1:0]  w_div_quo_next;
    logic             w_last;
    logic [XLEN-1:0]  w_multi_res;

    assign w_f7    = funct_i[9:3];
    assign w_f3    = funct_i[2:0];
    assign w_shamt = rs2_data_i[c_SHAMT_W-1:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        w_op = OP_ILL;
        case (ALUOp_i)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (w_f7)
                    7'b0000000: begin
                        case (w_f3)
                            3'b000:  w_op = OP_ADD;
                            3'b001:  w_op = OP_SLL;
                            3'b100:  w_op = OP_XOR;
                            3'b111:  w_op = OP_AND;
                            default: w_op = OP_ILL;
                        endcase
                    end
                    7'b0100000: begin
                        case (w_f3)
                            3'b000:  w_op = OP_SUB;
                            3'b101:  w_op = OP_SRA;
                            default: w_op = OP_ILL;
                        endcase
                    end
                    7'b0000001: begin
                        case (w_f3)
                            3'b000:  w_op = OP_MUL;
                            3'b101:  w_op = OP_DIVU;
                            3'b111:  w_op = OP_REMU;
                            default: w_op = OP_ILL;
                        endcase
                    end
                    default: w_op = OP_ILL;
                endcase
            end
            default: begin
                // I-type: funct7 is immediate bits for ADDI, so it is ignored
                if (w_f3 == 3'b000) begin
                    w_op = OP_ADD;
                end else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) begin
                    w_op = OP_SRA;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath (illegal ops fall through to zero)
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OP_ADD:  w_alu_res = rs1_data_i + rs2_data_i;
            OP_SUB:  w_alu_res = rs1_data_i - rs2_data_i;
            OP_SLL:  w_alu_res = rs1_data_i << w_shamt;
            OP_XOR:  w_alu_res = rs1_data_i ^ rs2_data_i;
            OP_AND:  w_alu_res = rs1_data_i & rs2_data_i;
            OP_SRA:  w_alu_res = $signed(rs1_data_i) >>> w_shamt;
            default: w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_sum = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (b_q[j]) begin
                w_mul_sum = w_mul_sum + (a_q << j);
            end
        end
    end

    assign w_mul_acc_next = acc_q + w_mul_sum;

    // Restoring division: bring in the next dividend bit, subtract when it
    // fits. A zero divisor always "fits", which yields all-ones quotient and
    // the dividend as remainder without special casing.
    assign w_rem_shift    = {acc_q, a_q[XLEN-1]};
    assign w_div_ge       = (w_rem_shift >= {1'b0, b_q});
    assign w_div_diff     = w_rem_shift[XLEN-1:0] - b_q;
    assign w_div_rem_next = w_div_ge ? w_div_diff : w_rem_shift[XLEN-1:0];
    assign w_div_quo_next = {a_q[XLEN-2:0], w_div_ge};

    assign w_last = (mop_q == M_MUL) ? (cnt_q == c_MUL_LAST) : (cnt_q == c_DIV_LAST);

    always_comb begin
        case (mop_q)
            M_MUL:   w_multi_res = w_mul_acc_next;
            M_DIVU:  w_multi_res = w_div_quo_next;
            default: w_multi_res = w_div_rem_next;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mop_d     = mop_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        zero_d    = zero_q;
        result_d  = result_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (w_op == OP_MUL || w_op == OP_DIVU || w_op == OP_REMU) begin
                        a_d     = rs1_data_i;
                        b_d     = rs2_data_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                        case (w_op)
                            OP_MUL:  mop_d = M_MUL;
                            OP_DIVU: mop_d = M_DIVU;
                            default: mop_d = M_REMU;
                        endcase
                    end else begin
                        valid_d   = 1'b1;
                        illegal_d = (w_op == OP_ILL);
                        result_d  = w_alu_res;
                        zero_d    = (w_alu_res == '0);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + c_CNT_W'(1);
                if (mop_q == M_MUL) begin
                    a_d   = a_q << MUL_STEP;
                    b_d   = b_q >> MUL_STEP;
                    acc_d = w_mul_acc_next;
                end else begin
                    a_d   = w_div_quo_next;
                    acc_d = w_div_rem_next;
                end
                // Result is registered on the last iteration so it is
                // presented together with valid_o during DONE.
                if (w_last) begin
                    state_d  = ST_DONE;
                    valid_d  = 1'b1;
                    result_d = w_multi_res;
                    zero_d   = (w_multi_res == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mop_q     <= M_MUL;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b1;
            result_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mop_q     <= mop_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
            result_q  <= result_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ready_o   = (state_q == ST_IDLE);
    assign stall_o   = (state_q == ST_BUSY);
    assign valid_o   = valid_q;
    assign illegal_o = illegal_q;
    assign zero_o    = zero_q;
    assign result_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit (XLEN=32, MUL_STEP=1):
//             directed cases plus randomized ops against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 1;

    logic            clk_i;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [9:0]      funct_i;
    logic [1:0]      ALUOp_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            illegal_o;
    logic            stall_o;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .funct_i    (funct_i),
        .ALUOp_i    (ALUOp_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .illegal_o  (illegal_o),
        .stall_o    (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural reference: result, illegal flag and latency (cycles from
    // acceptance edge to the valid_o cycle).
    function automatic void ref_op(input logic [1:0] aluop, input logic [9:0] funct,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic ill, output int lat);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] prod;
        f7 = funct[9:3];
        f3 = funct[2:0];
        res = 32'd0;
        ill = 1'b0;
        lat = 1;
        if (aluop == 2'b00) res = a + b;
        else if (aluop == 2'b01) res = a - b;
        else if (aluop == 2'b11) begin
            if (f3 == 3'b000) res = a + b;
            else if (f3 == 3'b101 && f7 == 7'h20) res = $signed(a) >>> b[4:0];
            else ill = 1'b1;
        end else if (f7 == 7'h00 && f3 == 3'b000) res = a + b;
        else if (f7 == 7'h00 && f3 == 3'b001) res = a << b[4:0];
        else if (f7 == 7'h00 && f3 == 3'b100) res = a ^ b;
        else if (f7 == 7'h00 && f3 == 3'b111) res = a & b;
        else if (f7 == 7'h20 && f3 == 3'b000) res = a - b;
        else if (f7 == 7'h20 && f3 == 3'b101) res = $signed(a) >>> b[4:0];
        else if (f7 == 7'h01 && f3 == 3'b000) begin
            prod = {32'd0, a} * {32'd0, b};
            res = prod[31:0];
            lat = XLEN / MUL_STEP + 1;
        end else if (f7 == 7'h01 && f3 == 3'b101) begin
            res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            lat = XLEN + 1;
        end else if (f7 == 7'h01 && f3 == 3'b111) begin
            res = (b == 0) ? a : a % b;
            lat = XLEN + 1;
        end else ill = 1'b1;
    endfunction

    // Issue one op from IDLE and check latency, stall window, result, flags
    // and the quiet cycle afterwards. Inputs are scrambled after acceptance.
    task automatic do_op(input string tag, input logic [1:0] aluop, input logic [9:0] funct,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        logic        exp_ill;
        int          lat;
        int          c;
        int          stall_cnt;
        ref_op(aluop, funct, a, b, exp_res, exp_ill, lat);
        check_val({tag, " ready_before"}, 32'(ready_o), 32'd1);
        valid_i    = 1'b1;
        ALUOp_i    = aluop;
        funct_i    = funct;
        rs1_data_i = a;
        rs2_data_i = b;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i    = 1'b0;
        ALUOp_i    = 2'($urandom);
        funct_i    = 10'($urandom);
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        c = 1;
        stall_cnt = 0;
        while (!valid_o && c < 100) begin
            if (stall_o && !ready_o) stall_cnt++;
            @(negedge clk_i);
            c++;
        end
        check_val({tag, " latency"}, 32'(c), 32'(lat));
        check_val({tag, " stall_cycles"}, 32'(stall_cnt), 32'(lat - 1));
        check_val({tag, " result"}, result_o, exp_res);
        check_val({tag, " zero"}, 32'(zero_o), 32'(exp_res == 0));
        check_val({tag, " illegal"}, 32'(illegal_o), 32'(exp_ill));
        check_val({tag, " stall_at_valid"}, 32'(stall_o), 32'd0);
        @(negedge clk_i);
        check_val({tag, " valid_drop"}, 32'(valid_o), 32'd0);
        check_val({tag, " illegal_drop"}, 32'(illegal_o), 32'd0);
        check_val({tag, " result_hold"}, result_o, exp_res);
        check_val({tag, " ready_after"}, 32'(ready_o), 32'd1);
    endtask

    typedef struct packed {
        logic [1:0] aluop;
        logic [9:0] funct;
    } enc_t;

    enc_t legal_tbl[13];

    initial begin
        int n_valid;
        int c;
        logic [31:0] second_res;
        logic accepted;

        legal_tbl = '{
            '{2'b00, 10'h000}, '{2'b01, 10'h000},
            '{2'b10, {7'h00, 3'b000}}, '{2'b10, {7'h00, 3'b001}},
            '{2'b10, {7'h00, 3'b100}}, '{2'b10, {7'h00, 3'b111}},
            '{2'b10, {7'h20, 3'b000}}, '{2'b10, {7'h20, 3'b101}},
            '{2'b10, {7'h01, 3'b000}}, '{2'b10, {7'h01, 3'b101}},
            '{2'b10, {7'h01, 3'b111}}, '{2'b11, {7'h55, 3'b000}},
            '{2'b11, {7'h20, 3'b101}}
        };

        rst_i = 1'b1;
        valid_i = 1'b0;
        ALUOp_i = 2'b00;
        funct_i = 10'd0;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
        repeat (3) @(negedge clk_i);
        check_val("rst ready", 32'(ready_o), 32'd1);
        check_val("rst valid", 32'(valid_o), 32'd0);
        check_val("rst result", result_o, 32'd0);
        check_val("rst zero", 32'(zero_o), 32'd1);
        check_val("rst illegal", 32'(illegal_o), 32'd0);
        check_val("rst stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed cases
        do_op("add", 2'b10, {7'h00, 3'b000}, 32'd5, 32'd7);
        do_op("sub_zero", 2'b01, 10'h000, 32'h1234, 32'h1234);
        do_op("sra", 2'b10, {7'h20, 3'b101}, 32'hFFFF_FFF8, 32'd1);
        do_op("srai", 2'b11, {7'h20, 3'b101}, 32'h8000_0000, 32'd31);
        do_op("sll", 2'b10, {7'h00, 3'b001}, 32'h0000_0001, 32'd31);
        do_op("mul", 2'b10, {7'h01, 3'b000}, 32'hFFFF_FFFF, 32'd3);
        do_op("divu", 2'b10, {7'h01, 3'b101}, 32'd100, 32'd7);
        do_op("remu", 2'b10, {7'h01, 3'b111}, 32'd100, 32'd7);
        do_op("divu0", 2'b10, {7'h01, 3'b101}, 32'd100, 32'd0);
        do_op("remu0", 2'b10, {7'h01, 3'b111}, 32'd100, 32'd0);
        do_op("illegal", 2'b10, {7'h7F, 3'b011}, 32'd9, 32'd9);
        do_op("illegal_i", 2'b11, {7'h00, 3'b101}, 32'd9, 32'd9);

        // Back-to-back single-cycle ops: a valid_o pulse each cycle
        valid_i = 1'b1;
        ALUOp_i = 2'b00;
        funct_i = 10'd0;
        for (int i = 0; i < 4; i++) begin
            rs1_data_i = 32'(i * 10);
            rs2_data_i = 32'd1;
            @(posedge clk_i);
            @(negedge clk_i);
            check_val("b2b valid", 32'(valid_o), 32'd1);
            check_val("b2b result", result_o, 32'(i * 10 + 1));
            check_val("b2b ready", 32'(ready_o), 32'd1);
        end
        valid_i = 1'b0;
        @(negedge clk_i);

        // Request held during BUSY is taken only once ready_o returns
        valid_i = 1'b1;
        ALUOp_i = 2'b10;
        funct_i = {7'h01, 3'b000};
        rs1_data_i = 32'hFFFF_FFFF;
        rs2_data_i = 32'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        funct_i = {7'h00, 3'b000};
        rs1_data_i = 32'd5;
        rs2_data_i = 32'd7;
        n_valid = 0;
        second_res = 32'd0;
        accepted = 1'b0;
        c = 1;
        while (c < 60) begin
            if (valid_o) begin
                n_valid++;
                if (n_valid == 1) begin
                    check_val("held mul cycle", 32'(c), 32'd33);
                    check_val("held mul result", result_o, 32'hFFFF_FFFD);
                end else begin
                    second_res = result_o;
                    check_val("held add cycle", 32'(c), 32'd35);
                end
            end
            if (ready_o && valid_i) accepted = 1'b1;
            @(negedge clk_i);
            if (accepted) valid_i = 1'b0;
            c++;
        end
        check_val("held pulses", 32'(n_valid), 32'd2);
        check_val("held add result", second_res, 32'd12);

        // Reset during MUL aborts it silently
        valid_i = 1'b1;
        ALUOp_i = 2'b10;
        funct_i = {7'h01, 3'b000};
        rs1_data_i = 32'd123;
        rs2_data_i = 32'd456;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check_val("abort stall_mid", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_val("abort ready", 32'(ready_o), 32'd1);
        check_val("abort stall", 32'(stall_o), 32'd0);
        check_val("abort result", result_o, 32'd0);
        check_val("abort zero", 32'(zero_o), 32'd1);
        n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) n_valid++;
            @(negedge clk_i);
        end
        check_val("abort no_valid", 32'(n_valid), 32'd0);
        do_op("post_abort_add", 2'b00, 10'h000, 32'd40, 32'd2);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            enc_t e;
            logic [31:0] a;
            logic [31:0] b;
            if ($urandom_range(0, 3) != 0) begin
                e = legal_tbl[$urandom_range(0, 12)];
            end else begin
                e.aluop = 2'($urandom);
                e.funct = 10'($urandom);
            end
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            do_op("rand", e.aluop, e.funct, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU control decode.
- Decodes funct/ALUOp and executes the operation in one block.
- Adds multi-cycle unsigned MUL/DIVU/REMU (M-extension subset) with a valid/ready handshake and a pipeline stall output.
- Sits in the EX stage; hazard unit freezes IF/ID/EX while stall_o is high.

Parameters:
- XLEN, 32: operand/result width (≥8, power of 2).
- MUL_STEP, 1: multiplier bits retired per cycle; must divide XLEN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept; request accepted when valid_i && ready_o at a rising edge.
- funct_i  in  10  {funct7[6:0], funct3[2:0]}.
- ALUOp_i  in  2  00 ld/sd address, 01 branch, 10 R-type, 11 I-type arith.
- rs1_data_i  in  XLEN  operand A.
- rs2_data_i  in  XLEN  operand B (immediate already muxed in).
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result, held until the next valid_o.
- zero_o  out  1  result_o == 0, registered with result_o.
- illegal_o  out  1  pulses with valid_o for an undecodable funct/ALUOp.
- stall_o  out  1  high while a multi-cycle op is in flight.

Behaviour:
- Reset values: ready_o=1, valid_o=0, result_o=0, zero_o=1, illegal_o=0, stall_o=0, state=IDLE, iteration counter=0.
- Decode (f7=funct_i[9:3], f3=funct_i[2:0]):
  - ALUOp 00: ADD.
  - ALUOp 01: SUB.
  - ALUOp 10, f7=0000000: f3 000 ADD, 001 SLL, 100 XOR, 111 AND.
  - ALUOp 10, f7=0100000: f3 000 SUB, 101 SRA.
  - ALUOp 10, f7=0000001: f3 000 MUL, 101 DIVU, 111 REMU.
  - ALUOp 11: f3 000 ADDI→ADD; f3 101 with f7=0100000 SRAI→SRA.
  - All other combinations are illegal.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use rs2[log2(XLEN)-1:0]; SRA is arithmetic.
  - MUL returns the low XLEN bits of the unsigned product.
- Single-cycle ops and illegal ops:
  - Accepted at edge k → valid_o=1 with the result in the cycle after edge k.
  - Illegal ops: result_o=0, illegal_o=1.
  - ready_o stays 1, so back-to-back single-cycle ops give a valid_o pulse every cycle.
- FSM states:
  - IDLE: ready_o=1. Accepting MUL/DIVU/REMU latches operands, clears the counter, goes to BUSY, ready_o=0.
  - BUSY: stall_o=1, ready_o=0.
    - MUL: shift-add, MUL_STEP bits per cycle, XLEN/MUL_STEP iterations.
    - DIVU/REMU: restoring division, 1 bit per cycle, XLEN iterations.
    - After the last iteration → DONE.
  - DONE: one cycle. Drive result_o, valid_o=1, zero_o, stall_o=0; → IDLE, ready_o=1 next cycle.
- Multi-cycle latency: valid_o high exactly N+1 cycles after the acceptance edge.
  - N = XLEN/MUL_STEP for MUL, N = XLEN for divides.
- Divide by zero: no early exit; full latency is kept.
  - DIVU returns all ones.
  - REMU returns rs1.
- valid_i while ready_o=0: ignored, no side effects; upstream holds the request.
- Operands and funct are sampled only at acceptance; input changes during BUSY have no effect.
- rst_i in any state:
  - Immediately (next edge) returns to reset values.
  - The in-flight op is discarded; no valid_o is produced for it.
  - rst_i has priority over acceptance in the same cycle.
- Between valid_o pulses: valid_o=0 and illegal_o=0; result_o and zero_o hold their last values.

Test Plan (XLEN=32, MUL_STEP=1):
- ALUOp=10, funct=0000000_000, rs1=5, rs2=7 → next cycle valid_o=1, result_o=12, zero_o=0; ready_o never drops.
- ALUOp=01, rs1=rs2=0x1234 → result_o=0, zero_o=1. Then ALUOp=10, funct=0100000_101, rs1=0xFFFFFFF8, rs2=1 → result_o=0xFFFFFFFC.
- ALUOp=10, funct=0000001_000, rs1=0xFFFFFFFF, rs2=3:
  - stall_o=1 and ready_o=0 for 32 cycles.
  - valid_o on cycle 33 with result_o=0xFFFFFFFD.
  - A valid_i held during BUSY is accepted only once ready_o returns.
- DIVU then REMU with rs1=100, rs2=7 → 14 and 2, each 33 cycles after acceptance. With rs2=0 → 0xFFFFFFFF and 100 respectively.
- MUL started, rst_i asserted at cycle 10 for one cycle → next cycle: ready_o=1, stall_o=0, result_o=0, zero_o=1, and no valid_o for the aborted op. A fresh ADD then completes normally.
- ALUOp=10, funct=1111111_011 → valid_o=1, illegal_o=1, result_o=0 one cycle after acceptance.
